// File: rtl/record_writer_if.sv
// Write channel from the song recorder to the note buffer.
// The master raises wr_valid with a stable address/data pair; the slave accepts with wr_ready.
interface record_writer_if #(
  parameter int ADDR_BITS = 6,
  parameter int DATA_BITS = 31
);
  logic                 wr_valid;
  logic                 wr_ready;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [DATA_BITS-1:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/record_writer.sv
// Song recorder: turns hit-button edges into {octave, note, length, delta} buffer entries.
// A session opens when en rises, records up to DEPTH notes and closes with a one-cycle done.
// ADDR_BITS must equal log2(DEPTH); track is one bit wider so it can hold DEPTH itself.
module record_writer #(
  parameter int DEPTH      = 64,
  parameter int ADDR_BITS  = 6,
  parameter int CLOCK_BITS = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  en_hit,
  input  logic                  oct_up,
  input  logic                  oct_down,
  input  logic [6:0]            note_key,
  input  logic [3:0]            length_key,
  input  logic [CLOCK_BITS-1:0] system_clock,
  record_writer_if.master       wr,
  output logic [ADDR_BITS:0]    track,
  output logic                  full,
  output logic                  done,
  output logic [1:0]            octave
);
  localparam int DATA_BITS = 2 + 3 + 2 + CLOCK_BITS;
  localparam logic [ADDR_BITS:0] TRACK_MAX = (ADDR_BITS + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ARM, WRITE, FULL} state_t;

  state_t                state_reg, state_next;
  logic                  hit_prev_reg, up_prev_reg, down_prev_reg;
  logic                  hit_rise, up_rise, down_rise;
  logic [ADDR_BITS:0]    track_reg, track_inc;
  logic [1:0]            octave_reg;
  logic [CLOCK_BITS-1:0] last_clock_reg;
  logic [ADDR_BITS-1:0]  addr_reg;
  logic [DATA_BITS-1:0]  data_reg;
  logic                  done_reg;
  logic [2:0]            note_code;
  logic [1:0]            length_code;
  logic                  arm_entry, capture, transfer, close;

  assign hit_rise  = en_hit   & ~hit_prev_reg;
  assign up_rise   = oct_up   & ~up_prev_reg;
  assign down_rise = oct_down & ~down_prev_reg;
  assign track_inc = track_reg + 1'b1;

  assign arm_entry = (state_reg == IDLE) && en;
  // A hit in the same cycle en drops is not recorded: en must still be high.
  assign capture   = (state_reg == ARM) && en && hit_rise;
  assign transfer  = (state_reg == WRITE) && wr.wr_ready;
  // Closing from WRITE waits for the pending transfer, then pulses done right after it.
  assign close     = (((state_reg == ARM) || (state_reg == FULL)) && !en) || (transfer && !en);

  // Lowest set switch wins; no note switch means a rest, no length switch means length 2.
  always_comb begin
    note_code   = 3'd0;
    length_code = 2'd2;
    for (int i = 6; i >= 0; i--) begin
      if (note_key[i]) note_code = 3'(i + 1);
    end
    for (int j = 3; j >= 0; j--) begin
      if (length_key[j]) length_code = 2'(j);
    end
  end

  // State register and the registered done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= close;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (en) state_next = ARM;
      ARM: begin
        if (!en)           state_next = IDLE;
        else if (hit_rise) state_next = WRITE;
      end
      WRITE: begin
        if (wr.wr_ready) begin
          if (!en)                         state_next = IDLE;
          else if (track_inc == TRACK_MAX) state_next = FULL;
          else                             state_next = ARM;
        end
      end
      FULL:  if (!en) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from the state and the committed entry count.
  always_comb begin
    wr.wr_valid = (state_reg == WRITE);
    full        = (track_reg == TRACK_MAX);
  end

  assign wr.wr_addr = addr_reg;
  assign wr.wr_data = data_reg;
  assign track      = track_reg;
  assign octave     = octave_reg;
  assign done       = done_reg;

  // Edge detectors, octave register, entry capture and the committed-entry counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_prev_reg   <= en_hit;
      up_prev_reg    <= oct_up;
      down_prev_reg  <= oct_down;
      track_reg      <= '0;
      octave_reg     <= 2'd1;
      last_clock_reg <= '0;
      addr_reg       <= '0;
      data_reg       <= '0;
    end else begin
      hit_prev_reg  <= en_hit;
      up_prev_reg   <= oct_up;
      down_prev_reg <= oct_down;

      if (up_rise && !down_rise && (octave_reg != 2'd3)) begin
        octave_reg <= octave_reg + 2'd1;
      end else if (down_rise && !up_rise && (octave_reg != 2'd0)) begin
        octave_reg <= octave_reg - 2'd1;
      end

      if (arm_entry) begin
        track_reg      <= '0;
        last_clock_reg <= system_clock;
      end

      // Delta wraps modulo 2^CLOCK_BITS, so a plain subtraction is exact.
      if (capture) begin
        addr_reg       <= track_reg[ADDR_BITS-1:0];
        data_reg       <= {octave_reg, note_code, length_code, system_clock - last_clock_reg};
        last_clock_reg <= system_clock;
      end

      if (transfer) begin
        track_reg <= track_inc;
      end
    end
  end
endmodule

// File: tb/tb_record_writer.sv
// Randomized bench for record_writer with a session-level reference model and directed scenarios.
module tb_record_writer;
  localparam int DEPTH = 4;
  localparam int AB    = 2;
  localparam int CB    = 24;
  localparam int DB    = 2 + 3 + 2 + CB;

  logic          clk = 1'b0;
  logic          rst, en, en_hit, oct_up, oct_down;
  logic [6:0]    note_key;
  logic [3:0]    length_key;
  logic [CB-1:0] system_clock;
  logic [AB:0]   track;
  logic          full, done;
  logic [1:0]    octave;

  int n_pass  = 0;
  int n_total = 0;
  bit cmp_en  = 1'b0;

  record_writer_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) intf ();

  record_writer #(.DEPTH(DEPTH), .ADDR_BITS(AB), .CLOCK_BITS(CB)) dut (
    .clk(clk), .rst(rst), .en(en), .en_hit(en_hit), .oct_up(oct_up), .oct_down(oct_down),
    .note_key(note_key), .length_key(length_key), .system_clock(system_clock),
    .wr(intf), .track(track), .full(full), .done(done), .octave(octave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic int note_of(input logic [6:0] k);
    for (int i = 0; i < 7; i++) if (k[i]) return i + 1;
    return 0;
  endfunction

  function automatic int len_of(input logic [3:0] k);
    for (int i = 0; i < 4; i++) if (k[i]) return i;
    return 2;
  endfunction

  // Reference model: a session is either closed or open; an open session may hold one pending entry.
  bit          m_active, m_pending, m_done;
  bit          m_hit_prev, m_up_prev, m_down_prev;
  int          m_count, m_oct;
  longint      m_last;
  logic [AB-1:0] m_addr;
  logic [DB-1:0] m_data;
  bit          hr, ur, dr;
  int          oct_before;
  longint      delta;

  // Model advances once per clock edge from the sampled inputs.
  always @(posedge clk) begin
    hr = en_hit && !m_hit_prev;
    ur = oct_up && !m_up_prev;
    dr = oct_down && !m_down_prev;
    m_hit_prev  = en_hit;
    m_up_prev   = oct_up;
    m_down_prev = oct_down;
    if (rst) begin
      m_active = 0; m_pending = 0; m_done = 0;
      m_count = 0; m_oct = 1; m_last = 0; m_addr = '0; m_data = '0;
    end else begin
      oct_before = m_oct;
      if (ur && !dr && m_oct < 3) m_oct = m_oct + 1;
      if (dr && !ur && m_oct > 0) m_oct = m_oct - 1;
      m_done = 0;
      if (!m_active) begin
        if (en) begin
          m_active = 1; m_count = 0; m_last = longint'(system_clock);
        end
      end else if (m_pending) begin
        if (intf.wr_ready) begin
          $display("xfer addr=%0d data=0x%0h track=%0d", m_addr, m_data, m_count + 1);
          m_pending = 0;
          m_count++;
          if (!en) begin m_active = 0; m_done = 1; end
        end
      end else if (!en) begin
        m_active = 0; m_done = 1;
      end else if (hr && m_count < DEPTH) begin
        delta = (longint'(system_clock) - m_last + 64'd16777216) % 64'd16777216;
        m_pending = 1;
        m_addr = AB'(m_count);
        m_data = DB'((longint'(oct_before) * 32 + longint'(note_of(note_key)) * 4
                      + longint'(len_of(length_key))) * 64'd16777216 + delta);
        m_last = longint'(system_clock);
      end
    end
  end

  // Every-cycle comparison of all DUT outputs against the model.
  always @(posedge clk) begin
    #1;
    if (cmp_en) begin
      check("wr_valid", 64'(intf.wr_valid), 64'(m_pending));
      check("wr_addr",  64'(intf.wr_addr),  64'(m_addr));
      check("wr_data",  64'(intf.wr_data),  64'(m_data));
      check("track",    64'(track),         64'(m_count));
      check("full",     64'(full),          64'(m_count == DEPTH));
      check("done",     64'(done),          64'(m_done));
      check("octave",   64'(octave),        64'(m_oct));
    end
  end

  initial begin
    rst = 1; en = 0; en_hit = 0; oct_up = 0; oct_down = 0;
    note_key = '0; length_key = '0; system_clock = '0; intf.wr_ready = 0;
    step(); step(); step();
    rst = 0;
    check("reset_valid",  64'(intf.wr_valid), 64'd0);
    check("reset_track",  64'(track), 64'd0);
    check("reset_octave", 64'(octave), 64'd1);
    check("reset_done",   64'(done), 64'd0);
    cmp_en = 1;

    // First note: octave 1, note 3, length 1, zero delta.
    system_clock = 24'd100; en = 1; step();
    note_key = 7'b0000100; length_key = 4'b0010; en_hit = 1; intf.wr_ready = 1; step();
    check("first_valid", 64'(intf.wr_valid), 64'd1);
    check("first_addr",  64'(intf.wr_addr), 64'd0);
    check("first_data",  64'(intf.wr_data), 64'({2'd1, 3'd3, 2'd1, 24'd0}));
    check("model_first_data", 64'(m_data), 64'({2'd1, 3'd3, 2'd1, 24'd0}));
    en_hit = 0; step();
    check("first_track", 64'(track), 64'd1);

    // Second note with a stalled slave; an extra hit edge while pending is dropped.
    system_clock = 24'd250; en_hit = 1; intf.wr_ready = 0; step();
    check("stall_data0", 64'(intf.wr_data), 64'({2'd1, 3'd3, 2'd1, 24'd150}));
    for (int k = 0; k < 4; k++) begin
      en_hit = (k == 1); step();
      check("stall_valid", 64'(intf.wr_valid), 64'd1);
      check("stall_data",  64'(intf.wr_data), 64'({2'd1, 3'd3, 2'd1, 24'd150}));
      check("stall_track", 64'(track), 64'd1);
    end
    en_hit = 0; intf.wr_ready = 1; step();
    check("stall_track_after", 64'(track), 64'd2);

    // Fill the buffer; hits beyond DEPTH produce no request.
    for (int h = 0; h < 4; h++) begin
      system_clock = system_clock + 24'd10; en_hit = 1; step();
      if (h >= 2) check("full_no_valid", 64'(intf.wr_valid), 64'd0);
      en_hit = 0; step();
    end
    check("full_flag",  64'(full), 64'd1);
    check("full_track", 64'(track), 64'd4);
    check("model_full_count", 64'(m_count), 64'd4);

    // Close from FULL: one-cycle done, track held afterwards.
    en = 0; step();
    check("close_done", 64'(done), 64'd1);
    step();
    check("close_done_off", 64'(done), 64'd0);
    check("idle_track_hold", 64'(track), 64'd4);

    // Close requested while a write is pending.
    en = 1; system_clock = 24'd500; step();
    check("rearm_track", 64'(track), 64'd0);
    en_hit = 1; intf.wr_ready = 0; system_clock = 24'd520; step();
    en_hit = 0; en = 0; step();
    check("pend_valid", 64'(intf.wr_valid), 64'd1);
    check("pend_done",  64'(done), 64'd0);
    intf.wr_ready = 1; step();
    check("pend_track", 64'(track), 64'd1);
    check("pend_done_pulse", 64'(done), 64'd1);
    step();
    check("pend_done_off", 64'(done), 64'd0);

    // Octave saturation and simultaneous edges.
    for (int i = 0; i < 3; i++) begin oct_up = 1; step(); oct_up = 0; step(); end
    check("oct_sat_hi", 64'(octave), 64'd3);
    oct_up = 1; oct_down = 1; step(); oct_up = 0; oct_down = 0; step();
    check("oct_both", 64'(octave), 64'd3);
    for (int i = 0; i < 4; i++) begin oct_down = 1; step(); oct_down = 0; step(); end
    check("oct_sat_lo", 64'(octave), 64'd0);
    check("model_oct_lo", 64'(m_oct), 64'd0);

    // Timestamp wrap-around, then reset in the middle of a pending write.
    system_clock = 24'hFFFFF0; en = 1; step();
    system_clock = 24'h000010; en_hit = 1; intf.wr_ready = 1; step();
    check("wrap_data", 64'(intf.wr_data), 64'({2'd0, 3'd3, 2'd1, 24'h000020}));
    check("model_wrap_data", 64'(m_data), 64'({2'd0, 3'd3, 2'd1, 24'h000020}));
    en_hit = 0; intf.wr_ready = 0; rst = 1; step();
    check("rst_mid_valid", 64'(intf.wr_valid), 64'd0);
    check("rst_mid_track", 64'(track), 64'd0);
    rst = 0;

    // Randomized traffic.
    en = 1;
    for (int c = 0; c < 4000; c++) begin
      rst          = ($urandom_range(0, 249) == 0);
      if ($urandom_range(0, 39) == 0) en = ~en;
      en_hit       = ($urandom_range(0, 2) == 0);
      oct_up       = ($urandom_range(0, 5) == 0);
      oct_down     = ($urandom_range(0, 5) == 0);
      note_key     = ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom);
      length_key   = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
      if ($urandom_range(0, 99) == 0) system_clock = 24'hFFFFE0;
      else system_clock = system_clock + 24'($urandom_range(1, 40));
      intf.wr_ready = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
